// File: rtl/msym_pkg.sv
// msym_pkg: shared state encoding, carry width and beat-count helper for the normalization sequencer
package msym_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} msym_state_e;
  // A symbol of LOGRADIX+1 bits plus a carry of 2 shifts down to at most 2, so two bits always hold it.
  localparam int CARRYBITS = 2;
  function automatic int numbeats(input int numsymbols, input int symbolspercycle);
    return numsymbols / symbolspercycle;
  endfunction
endpackage

// File: rtl/msym_carry_slice.sv
// msym_carry_slice: combinational carry ripple over one beat of redundant symbols
//   i_symbols : SYMBOLSPERCYCLE redundant symbols, index 0 least significant
//   i_carry   : carry entering the lowest symbol of the beat
//   o_digits  : SYMBOLSPERCYCLE canonical LOGRADIX-bit digits
//   o_carry   : carry leaving the highest symbol of the beat
module msym_carry_slice
  import msym_pkg::*;
#(
  parameter int LOGRADIX = 33,
  parameter int SYMBOLSPERCYCLE = 4
) (
  input  logic [SYMBOLSPERCYCLE-1:0][LOGRADIX:0]  i_symbols,
  input  logic [CARRYBITS-1:0]                    i_carry,
  output logic [SYMBOLSPERCYCLE*LOGRADIX-1:0]     o_digits,
  output logic [CARRYBITS-1:0]                    o_carry
);
  logic [CARRYBITS-1:0] w_c [SYMBOLSPERCYCLE+1];
  assign w_c[0] = i_carry;
  for (genvar g = 0; g < SYMBOLSPERCYCLE; g++) begin : g_sym
    logic [LOGRADIX+1:0] w_t;
    assign w_t = {1'b0, i_symbols[g]} + {LOGRADIX'(0), w_c[g]};
    assign o_digits[g*LOGRADIX +: LOGRADIX] = w_t[LOGRADIX-1:0];
    assign w_c[g+1] = w_t[LOGRADIX+1:LOGRADIX];
  end
  assign o_carry = w_c[SYMBOLSPERCYCLE];
endmodule

// File: rtl/msym_normalize_seq.sv
// msym_normalize_seq: multi-cycle carry normalization of a redundant multi-symbol operand
//   in_valid/in_ready/in_symbols : operand handshake, accepted only in IDLE
//   out_valid/out_ready          : result handshake, held in DONE until out_ready
//   out_data/out_carry           : canonical value and overflow above NUMSYMBOLS*LOGRADIX bits
//   busy                         : high while an operand is being processed or held
module msym_normalize_seq
  import msym_pkg::*;
#(
  parameter int NUMSYMBOLS = 32,
  parameter int LOGRADIX = 33,
  parameter int SYMBOLSPERCYCLE = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUMSYMBOLS-1:0][LOGRADIX:0]  in_symbols,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUMSYMBOLS*LOGRADIX-1:0]     out_data,
  output logic [CARRYBITS-1:0]               out_carry,
  output logic                               busy
);
  localparam int NB = numbeats(NUMSYMBOLS, SYMBOLSPERCYCLE);
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int SW = SYMBOLSPERCYCLE * LOGRADIX;
  typedef logic [LOGRADIX:0] sym_t;
  if (NUMSYMBOLS % SYMBOLSPERCYCLE != 0) begin : g_bad_spc
    $error("msym_normalize_seq: SYMBOLSPERCYCLE must divide NUMSYMBOLS");
  end
  msym_state_e r_state, w_next;
  // Operand and result are held beat-major so the active beat is a plain index, not a shifted slice.
  sym_t [NB-1:0][SYMBOLSPERCYCLE-1:0] r_syms;
  logic [NB-1:0][SW-1:0] r_data;
  logic [BW-1:0] r_beat;
  logic [CARRYBITS-1:0] r_carry, w_carry;
  logic [SW-1:0] w_digits;
  logic w_accept, w_last;
  assign w_accept = r_state == IDLE && in_valid;
  assign w_last = r_beat == BW'(NB - 1);
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = w_accept ? RUN
           : (r_state == RUN && w_last) ? DONE
           : (r_state == DONE && out_ready) ? IDLE
           : r_state;
  end
  always_comb begin
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    busy = r_state != IDLE;
  end
  msym_carry_slice #(
    .LOGRADIX(LOGRADIX),
    .SYMBOLSPERCYCLE(SYMBOLSPERCYCLE)
  ) u_slice (
    .i_symbols(r_syms[r_beat]),
    .i_carry(r_carry),
    .o_digits(w_digits),
    .o_carry(w_carry)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
      r_carry <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_syms <= in_symbols;
      r_beat <= '0;
      r_carry <= '0;
    end else if (r_state == RUN) begin
      r_data[r_beat] <= w_digits;
      r_carry <= w_carry;
      r_beat <= r_beat + BW'(1);
    end
  end
  assign out_data = r_data;
  assign out_carry = r_carry;
endmodule

// File: tb/tb_msym_normalize_seq.sv
// tb_msym_normalize_seq: directed small-parameter checks plus randomized default-parameter run against an arithmetic model
module tb_msym_normalize_seq;
  localparam int BNS = 32;
  localparam int BLR = 33;
  localparam int BSPC = 4;
  localparam int BNB = BNS / BSPC;
  localparam int BDW = BNS * BLR;
  localparam int NRAND = 1000;
  localparam int NRT = 60;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_busy;
  logic [3:0][4:0] s_in_symbols = '0;
  logic [15:0] s_out_data;
  logic [1:0] s_out_carry;
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [BNS-1:0][BLR:0] b_in_symbols = '0;
  logic [BDW-1:0] b_out_data;
  logic [1:0] b_out_carry;
  int checks = 0;
  int failures = 0;
  msym_normalize_seq #(.NUMSYMBOLS(4), .LOGRADIX(4), .SYMBOLSPERCYCLE(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_symbols(s_in_symbols),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_carry(s_out_carry),
    .busy(s_busy)
  );
  msym_normalize_seq #(.NUMSYMBOLS(BNS), .LOGRADIX(BLR), .SYMBOLSPERCYCLE(BSPC)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_symbols(b_in_symbols),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_carry(b_out_carry),
    .busy(b_busy)
  );
  task automatic chk(input string nm, input logic [1087:0] act, input logic [1087:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act[191:0], exp[191:0]);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [BDW+1:0] msum(input logic [BNS-1:0][BLR:0] s);
    logic [BDW+1:0] acc, t;
    acc = '0;
    for (int i = 0; i < BNS; i++) begin
      t = '0;
      t[BLR:0] = s[i];
      acc = acc + (t << (i * BLR));
    end
    return acc;
  endfunction
  task automatic s_idle_chk(input string nm);
    chk({nm, "_in_ready"}, s_in_ready, 1'b1);
    chk({nm, "_out_valid"}, s_out_valid, 1'b0);
    chk({nm, "_busy"}, s_busy, 1'b0);
  endtask
  task automatic s_run(input string nm, input logic [3:0][4:0] syms, input logic [15:0] ed,
                       input logic [1:0] ec, input logic rdy);
    s_in_symbols = syms;
    s_in_valid = 1'b1;
    s_out_ready = rdy;
    step();
    s_in_valid = 1'b0;
    chk({nm, "_busy_run"}, s_busy, 1'b1);
    chk({nm, "_in_ready_run"}, s_in_ready, 1'b0);
    chk({nm, "_valid_early1"}, s_out_valid, 1'b0);
    step();
    chk({nm, "_valid_early2"}, s_out_valid, 1'b0);
    step();
    chk({nm, "_valid"}, s_out_valid, 1'b1);
    chk({nm, "_data"}, s_out_data, ed);
    chk({nm, "_carry"}, s_out_carry, ec);
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    s_idle_chk({nm, "_after"});
  endtask
  initial begin
    logic [BNS-1:0][BLR:0] pin;
    logic [BDW+1:0] psum;
    int m_st, m_cnt, cyc, results, last_acc, n_acc;
    logic [BDW+1:0] m_exp;
    logic [BDW-1:0] m_src;
    logic m_rt, rt, acc_dut;
    logic [63:0] r64;
    logic [BLR:0] sym;
    int kind;
    pin = '0;
    pin[0] = '1;
    psum = msum(pin);
    chk("pin_model_low", psum, {{(BDW-BLR+1){1'b0}}, 34'h3FFFFFFFF});
    for (int i = 0; i < BNS; i++) pin[i] = 34'h200000000;
    psum = msum(pin);
    chk("pin_model_carry", psum[BDW+1:BDW], 2'd1);
    chk("pin_model_digit1", psum[65:33], 33'h1);
    chk("pin_model_digit0", psum[32:0], 33'h0);
    repeat (5) step();
    rst = 1'b0;
    s_idle_chk("reset");
    chk("reset_data", s_out_data, 16'h0);
    chk("reset_carry", s_out_carry, 2'd0);
    chk("reset_big_in_ready", b_in_ready, 1'b1);
    chk("reset_big_valid", b_out_valid, 1'b0);
    chk("reset_big_data", b_out_data, '0);
    s_run("all10", {4{5'h10}}, 16'h1110, 2'd1, 1'b0);
    s_run("all1f", {4{5'h1F}}, 16'h110F, 2'd2, 1'b0);
    s_in_symbols = {4{5'h10}};
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    step();
    step();
    chk("bp_valid_rise", s_out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      s_in_valid = k[0];
      s_in_symbols = {4{5'h1F}};
      step();
      chk("bp_valid", s_out_valid, 1'b1);
      chk("bp_data", s_out_data, 16'h1110);
      chk("bp_carry", s_out_carry, 2'd1);
      chk("bp_in_ready", s_in_ready, 1'b0);
      chk("bp_busy", s_busy, 1'b1);
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    s_idle_chk("bp_release");
    s_in_symbols = {4{5'h1F}};
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_idle_chk("midrun_rst");
    chk("midrun_rst_data", s_out_data, 16'h0);
    chk("midrun_rst_carry", s_out_carry, 2'd0);
    s_run("post_rst", {5'h05, 5'h1E, 5'h00, 5'h1F}, 16'h6E1F, 2'd0, 1'b1);
    m_st = 0; m_cnt = 0; cyc = 0; results = 0; last_acc = 0; n_acc = 0;
    m_exp = '0; m_src = '0; m_rt = 1'b0;
    while (results < NRAND + NRT) begin
      chk("b_in_ready", b_in_ready, m_st == 0);
      chk("b_out_valid", b_out_valid, m_st == 2);
      chk("b_busy", b_busy, m_st != 0);
      if (m_st == 2) begin
        if (m_rt) begin
          chk("b_roundtrip_data", b_out_data, m_src);
          chk("b_roundtrip_carry", b_out_carry, 2'd0);
        end else begin
          chk("b_data", b_out_data, m_exp[BDW-1:0]);
          chk("b_carry", b_out_carry, m_exp[BDW+1:BDW]);
        end
      end
      rt = results >= NRAND;
      kind = $urandom_range(0, 3);
      for (int i = 0; i < BNS; i++) begin
        r64 = {$urandom(), $urandom()};
        sym = kind == 0 ? '1 : r64[BLR:0];
        if (rt) sym[BLR] = 1'b0;
        b_in_symbols[i] = sym;
      end
      b_in_valid = 1'b1;
      b_out_ready = 1'($urandom_range(0, 1));
      acc_dut = b_in_ready;
      @(posedge clk);
      cyc++;
      if (acc_dut) begin
        if (n_acc > 0) chk("b_accept_spacing", (cyc - last_acc) >= BNB + 2, 1'b1);
        last_acc = cyc;
        n_acc++;
      end
      if (m_st == 0) begin
        m_exp = msum(b_in_symbols);
        m_rt = rt;
        for (int i = 0; i < BNS; i++) m_src[i*BLR +: BLR] = b_in_symbols[i][BLR-1:0];
        m_st = 1;
        m_cnt = 0;
      end else if (m_st == 1) begin
        m_cnt++;
        if (m_cnt == BNB) m_st = 2;
      end else if (b_out_ready) begin
        m_st = 0;
        results++;
      end
      @(negedge clk);
      if (cyc > 60000) begin
        chk("b_timeout", 1'b0, 1'b1);
        break;
      end
    end
    b_in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
